// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master among NUM_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to add a WAIT-state watchdog (TIMEOUT_CYCLES).
module apb_req_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_sel,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [7:0]           resp_rdata,
  output logic                 resp_err,
  output logic                 m_start,
  output logic [1:0]           m_sel,
  output logic                 m_write,
  output logic [7:0]           m_addr,
  output logic [7:0]           m_wdata,
  input  logic [7:0]           m_rdata,
  input  logic                 m_done,
  output logic [1:0]           o_dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("apb_req_arbiter: NUM_REQ must be 2..4");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_req_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Handshake: a requester holds req_valid and its fields until req_ack pulses;
  // req_ack means the fields are captured, resp_valid pulses once at completion.
  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_last, w_last_nxt;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0] r_resp_valid, w_resp_valid_nxt;
  logic [7:0]         r_rdata, w_rdata_nxt;
  logic               r_err, w_err_nxt;
  logic               r_start, w_start_nxt;
  logic [1:0]         r_sel, w_sel_nxt;
  logic               r_write, w_write_nxt;
  logic [7:0]         r_addr, w_addr_nxt;
  logic [7:0]         r_wdata, w_wdata_nxt;

  logic [1:0]         w_sel_arr   [NUM_REQ];
  logic               w_write_arr [NUM_REQ];
  logic [7:0]         w_addr_arr  [NUM_REQ];
  logic [7:0]         w_wdata_arr [NUM_REQ];
  logic [IDX_W-1:0]   w_win, w_cand;
  logic               w_found;
  logic               w_sel_ok;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_sel_arr[g]   = req_sel[2*g +: 2];
    assign w_write_arr[g] = req_write[g];
    assign w_addr_arr[g]  = req_addr[8*g +: 8];
    assign w_wdata_arr[g] = req_wdata[8*g +: 8];
  end

  // Scan upward from the requester after the last winner, wrapping.
  always_comb begin
    w_win   = r_last;
    w_cand  = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDX_W'((int'(r_last) + i) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_win   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_sel_ok = (w_sel_arr[w_win] == 2'd1) || (w_sel_arr[w_win] == 2'd2);

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_wait_cnt, w_wait_cnt_nxt;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_last_nxt       = r_last;
    w_ack_nxt        = '0;
    w_resp_valid_nxt = '0;
    w_start_nxt      = 1'b0;
    w_rdata_nxt      = r_rdata;
    w_err_nxt        = r_err;
    w_sel_nxt        = r_sel;
    w_write_nxt      = r_write;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
`ifdef APB_ARB_TIMEOUT_EN
    w_wait_cnt_nxt   = r_wait_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_last_nxt       = w_win;
          w_ack_nxt[w_win] = 1'b1;
          w_write_nxt      = w_write_arr[w_win];
          w_addr_nxt       = w_addr_arr[w_win];
          w_wdata_nxt      = w_wdata_arr[w_win];
          if (w_sel_ok) begin
            w_sel_nxt   = w_sel_arr[w_win];
            w_start_nxt = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            // Illegal select: answer with an error without touching the master.
            w_sel_nxt               = 2'd0;
            w_err_nxt               = 1'b1;
            w_resp_valid_nxt[w_win] = 1'b1;
            w_state_nxt             = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
`ifdef APB_ARB_TIMEOUT_EN
        w_wait_cnt_nxt = 8'd0;
`endif
      end
      S_WAIT: begin
        if (m_done) begin
          w_rdata_nxt              = m_rdata;
          w_err_nxt                = 1'b0;
          w_sel_nxt                = 2'd0;
          w_resp_valid_nxt[r_last] = 1'b1;
          w_state_nxt              = S_DONE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (r_wait_cnt == TO_LAST) begin
          w_rdata_nxt              = 8'hFF;
          w_err_nxt                = 1'b1;
          w_sel_nxt                = 2'd0;
          w_resp_valid_nxt[r_last] = 1'b1;
          w_state_nxt              = S_DONE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
`endif
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last       <= LAST_INIT;
      r_ack        <= '0;
      r_resp_valid <= '0;
      r_rdata      <= 8'd0;
      r_err        <= 1'b0;
      r_start      <= 1'b0;
      r_sel        <= 2'd0;
      r_write      <= 1'b0;
      r_addr       <= 8'd0;
      r_wdata      <= 8'd0;
`ifdef APB_ARB_TIMEOUT_EN
      r_wait_cnt   <= 8'd0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_last       <= w_last_nxt;
      r_ack        <= w_ack_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_rdata      <= w_rdata_nxt;
      r_err        <= w_err_nxt;
      r_start      <= w_start_nxt;
      r_sel        <= w_sel_nxt;
      r_write      <= w_write_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
`ifdef APB_ARB_TIMEOUT_EN
      r_wait_cnt   <= w_wait_cnt_nxt;
`endif
    end
  end

  assign req_ack     = r_ack;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;
  assign m_start     = r_start;
  assign m_sel       = r_sel;
  assign m_write     = r_write;
  assign m_addr      = r_addr;
  assign m_wdata     = r_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Round-robin arbiter that shares the single APB master between NUM_REQ processor-side requesters, for example the CPU and the I2C sequencer.
- Latches the winning request and issues it to the master as a one-cycle start pulse.
- Holds the address, data and select fields stable until the master reports completion, then returns read data or error to the winner only.
- Sits between requesters and the APB master's processor-side port.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..4.
- TIMEOUT_CYCLES, 64: WAIT-state watchdog limit. Used only when APB_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until req_ack.
- req_sel  in  2*NUM_REQ  slave select per requester; 1 or 2 is legal.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  8*NUM_REQ  APB address per requester.
- req_wdata  in  8*NUM_REQ  write data per requester.
- req_ack  out  NUM_REQ  one-cycle grant pulse; fields have been captured.
- resp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- resp_rdata  out  8  read data; valid while any resp_valid bit is high.
- resp_err  out  1  error flag; valid while any resp_valid bit is high.
- m_start  out  1  start pulse to the APB master.
- m_sel  out  2  select to the APB master.
- m_write  out  1  write enable to the APB master.
- m_addr  out  8  address to the APB master.
- m_wdata  out  8  write data to the APB master.
- m_rdata  in  8  read data from the APB master.
- m_done  in  1  transfer-complete pulse from the APB master; m_rdata is valid in the same cycle.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - state returns to IDLE.
  - All outputs go to 0.
  - last_grant is set to NUM_REQ-1, so requester 0 wins first.
  - Any in-flight transfer is abandoned: no resp_valid is produced and m_start stays 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_valid bit is set, the winner w is the first set bit scanning upward from last_grant+1, wrapping modulo NUM_REQ.
  - At that edge: capture w's fields into the m_* registers, set last_grant to w, pulse req_ack[w].
  - If w's sel is 1 or 2: set m_start to 1 and go to ISSUE.
  - If w's sel is 0 or 3: do not start the master, set resp_err to 1, go to DONE.
  - If no req_valid bit is set, stay in IDLE.
- ISSUE: lasts exactly one cycle with m_start = 1 and req_ack[w] = 1. Next edge: m_start and req_ack go to 0, state goes to WAIT.
- WAIT:
  - m_sel, m_write, m_addr and m_wdata hold the captured values.
  - On m_done: resp_rdata takes m_rdata (for writes too; the value is don't-care), resp_err goes to 0, state goes to DONE.
  - An m_done seen in ISSUE or IDLE is ignored.
- DONE:
  - Exactly one cycle with resp_valid[w] = 1.
  - m_sel returns to 0, then state returns to IDLE.
  - resp_rdata holds its value until the next DONE.
- The one-cycle DONE→IDLE turnaround guarantees the master has returned to idle before the next start.
- Minimum request-to-response latency is 3 cycles plus the master's transfer time. Back-to-back grants are at least 4 cycles apart.
- Simultaneous requests are resolved strictly round-robin, so no requester is starved. With NUM_REQ = 2 and both requests held, grants alternate 0,1,0,1.
- A requester dropping req_valid before req_ack is legal; the request is simply not granted.
- req_valid seen after req_ack is treated as a new request.

Optional Feature:
- Macro name: APB_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES without m_done: go to DONE with resp_err = 1 and resp_rdata = 8'hFF, and set m_sel to 0.
  - A late m_done after the timeout is ignored.
- Undefined: no counter; WAIT waits indefinitely for m_done.

Test Plan:
- Reset held low for 2 cycles with req_valid = 2'b11 → all outputs 0, no req_ack. After release, requester 0 is granted first.
- Req0 read, sel = 1, addr = 8'h10; master returns m_done with m_rdata = 8'hA5 after 3 cycles → req_ack[0] pulse, one-cycle m_start, fields stable through WAIT, resp_valid[0] with resp_rdata = 8'hA5 and resp_err = 0.
- req_valid = 2'b11 held for 4 transfers → grant order 0,1,0,1; each resp_valid goes only to its own winner.
- Req1 with sel = 3 → req_ack[1], m_start never asserts, resp_valid[1] with resp_err = 1.
- Reset asserted in WAIT → next cycle state is IDLE and outputs are 0; no resp_valid follows a later m_done.
- With APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, m_done withheld → resp_valid with resp_err = 1 and resp_rdata = 8'hFF, 8 cycles after WAIT entry.
